key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Per-key synchroniser and debouncer for the board push-buttons. Takes the raw asynchronous key pins and produces clean debounced levels that drive the key PIO's in_port. Also produces one-cycle press and release pulses for local logic such as camera control triggers.

Parameters:
NUM_KEYS, 4, number of independent key inputs.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the output changes (20 ms at 50 MHz); must be >= 1.
CNT_WIDTH, 20, width of each per-key counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.
KEY_ACTIVE_LOW, 1, 1 = pressed key reads 0 (idle level 1); 0 = pressed reads 1 (idle level 0).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
key_in  input  NUM_KEYS  raw key pins, asynchronous to clk.
key_out  output  NUM_KEYS  debounced key level, same polarity as key_in; connects to PIO in_port.
key_press  output  NUM_KEYS  one-cycle pulse per key when key_out enters the pressed level.
key_release  output  NUM_KEYS  one-cycle pulse per key when key_out returns to the idle level.

Behaviour:
- Reset is asynchronous and active-high. It is fully effective while asserted.
- Reset values: sync stages and key_out = idle level (all ones if KEY_ACTIVE_LOW=1, else all zeros). All counters = 0. key_press = 0. key_release = 0.
- Synchroniser: 2-FF chain per bit, key_in -> s1 -> s2. Only s2 is used downstream.
- Each key is independent and has its own counter cnt[i]. The rules below are evaluated every clk edge.
  - If s2[i] == key_out[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: key_out[i] <= s2[i]; cnt[i] <= 0; fire the pulse for key i.
  - Else: cnt[i] <= cnt[i]+1.
- Pulse selection: if the new key_out[i] equals the pressed level, the pulse is key_press[i]; otherwise it is key_release[i].
- Pulses are registered. They are high in exactly the same cycle key_out[i] first shows the new value. They fall the next cycle, because s2 == key_out then clears the path.
- Latency: if key_in changes before edge k and stays stable, s2 differs from edge k+1. key_out changes at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges after first sampling.
- Glitches: any return of s2 to key_out's value before the count completes resets cnt to 0. The output never changes on a pulse shorter than DEBOUNCE_CYCLES stable cycles.
- Simultaneous events: keys changing in the same cycle each debounce independently. Multiple press/release bits may assert together.
- No wrap-around: cnt never exceeds DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: the output follows s2 one edge after mismatch.
- key_press and key_release for the same key are never high simultaneously.
- Reset mid-count: all state returns to reset values and any partial count is discarded. After deassertion, a held pressed key requires the full DEBOUNCE_CYCLES+2 edges, counted from the first edge after deassertion.
- No combinational path from key_in to any output.

Test Plan:
Bench configuration for all scenarios: NUM_KEYS=4, DEBOUNCE_CYCLES=8, CNT_WIDTH=4, KEY_ACTIVE_LOW=1.
1. Reset: key_in=4'hF, pulse reset for 3 cycles -> key_out=4'hF, key_press=0, key_release=0 during and after reset; no pulses over 20 idle cycles.
2. Press: key_in 4'hF->4'hE held -> key_out=4'hE exactly 10 edges after first sampling edge; key_press=4'b0001 for exactly one cycle; key_release stays 0.
3. Bounce: key_in[1] toggles low for 7 cycles then high for 2, repeated 5 times -> key_out stays 4'hF, no pulses. A following hold-low of 8+ cycles -> key_out=4'hD, key_press=4'b0010.
4. Release: from key_out=4'hE, key_in->4'hF held -> 10 edges later key_out=4'hF, key_release=4'b0001 one cycle, key_press=0.
5. Simultaneous: key_in 4'hF->4'h0 on one edge -> all key_out bits fall on the same edge, key_press=4'hF for one cycle. Return to 4'hF -> key_release=4'hF one cycle.
6. Reset mid-count: key_in[2] low for 5 cycles, assert reset (async, mid-cycle) -> key_out=4'hF immediately. After deassertion with key_in[2] still low, key_out[2] falls exactly 10 edges after the first post-reset edge; key_press=4'b0100 once.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchroniser plus stable-count debouncer.
// Produces clean key levels for the key PIO in_port and one-cycle press /
// release pulses for local logic (e.g. camera control triggers).
// All outputs come straight from flops; there is no combinational path
// from key_in to any output.

module key_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_out,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   // Idle (released) level of every key and the level a pressed key reads.
   localparam logic [NUM_KEYS-1:0] IDLE_LVL  = KEY_ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
   localparam logic                PRESS_LVL = KEY_ACTIVE_LOW ? 1'b0 : 1'b1;

   // Terminal count: the level is accepted on the edge that would otherwise
   // push the counter past this value, so it never wraps.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // True when a newly accepted level means the key went down.
   function automatic logic is_press_level(input logic lvl);
      return (lvl == PRESS_LVL);
   endfunction

   logic [NUM_KEYS-1:0]  sync1_r;
   logic [NUM_KEYS-1:0]  sync2_r;
   logic [NUM_KEYS-1:0]  level_r;
   logic [NUM_KEYS-1:0]  press_r;
   logic [NUM_KEYS-1:0]  release_r;
   logic [CNT_WIDTH-1:0] cnt_r [NUM_KEYS];

   logic [NUM_KEYS-1:0]  level_nxt_s;
   logic [NUM_KEYS-1:0]  press_nxt_s;
   logic [NUM_KEYS-1:0]  release_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_nxt_s [NUM_KEYS];

   // Two-flop synchroniser; the chain resets to the idle level so no
   // spurious edge is seen right after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= IDLE_LVL;
         sync2_r <= IDLE_LVL;
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
      end
   end

   // Per-key debounce decision: count consecutive mismatching cycles and
   // accept the new level once the count completes.
   always_comb begin
      level_nxt_s   = level_r;
      press_nxt_s   = {NUM_KEYS{1'b0}};
      release_nxt_s = {NUM_KEYS{1'b0}};
      cnt_nxt_s     = cnt_r;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (sync2_r[i] == level_r[i]) begin
            // Input agrees with the accepted level: discard any partial count.
            cnt_nxt_s[i] = CNT_ZERO;
         end else if (cnt_r[i] == CNT_LAST) begin
            // Stable long enough: take the new level and announce it.
            level_nxt_s[i] = sync2_r[i];
            cnt_nxt_s[i]   = CNT_ZERO;
            if (is_press_level(sync2_r[i])) begin
               press_nxt_s[i] = 1'b1;
            end else begin
               release_nxt_s[i] = 1'b1;
            end
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
         end
      end
   end

   // Debounce state and registered pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_r   <= IDLE_LVL;
         press_r   <= {NUM_KEYS{1'b0}};
         release_r <= {NUM_KEYS{1'b0}};
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         level_r   <= level_nxt_s;
         press_r   <= press_nxt_s;
         release_r <= release_nxt_s;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   assign key_out     = level_r;
   assign key_press   = press_r;
   assign key_release = release_r;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (NUM_KEYS=4, DEBOUNCE_CYCLES=8,
// CNT_WIDTH=4, active-low keys). The reference model accepts a new level
// once the synchronised input has disagreed with the current level on each
// of the last DEBOUNCE_CYCLES clock edges, using a sliding window of samples.

module tb_key_debounce;

   localparam int NK = 4;
   localparam int D  = 8;

   logic          clk;
   logic          reset;
   logic [NK-1:0] key_in;
   logic [NK-1:0] key_out;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [NK-1:0] m_s1, m_s2, m_out, m_press, m_rel;
   logic [NK-1:0] hist[$];

   key_debounce #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D),
      .CNT_WIDTH       (4),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .key_out     (key_out),
      .key_press   (key_press),
      .key_release (key_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1    = 4'hF;
      m_s2    = 4'hF;
      m_out   = 4'hF;
      m_press = 4'h0;
      m_rel   = 4'h0;
      hist.delete();
   endtask

   // One clock edge of the reference model.
   task automatic model_edge();
      bit all_diff;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_press = 4'h0;
      m_rel   = 4'h0;
      if (hist.size() == D) begin
         for (int k = 0; k < NK; k++) begin
            all_diff = 1'b1;
            foreach (hist[j]) if (hist[j][k] == m_out[k]) all_diff = 1'b0;
            if (all_diff) begin
               m_out[k] = m_s2[k];
               if (m_s2[k] == 1'b0) m_press[k] = 1'b1;
               else                 m_rel[k]   = 1'b1;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = key_in;
   endtask

   // Advance one clock, update the model, then compare just after the edge.
   task automatic tick();
      @(posedge clk);
      if (!reset) model_edge();
      #1;
      chk("model_key_out", key_out, m_out);
      chk("model_key_press", key_press, m_press);
      chk("model_key_release", key_release, m_rel);
      chk("press_release_exclusive", key_press & key_release, 4'h0);
   endtask

   // Count edges until key_out changes; check latency, new level and pulses.
   task automatic wait_change(input string name, input int exp_n, input logic [3:0] exp_out,
                              input logic [3:0] exp_p, input logic [3:0] exp_r);
      logic [3:0] prev;
      int  n;
      bit  seen;
      prev = key_out;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (key_out != prev) seen = 1'b1;
      end
      chk({name, "_latency"}, n, exp_n);
      chk({name, "_key_out"}, key_out, exp_out);
      chk({name, "_press"}, key_press, exp_p);
      chk({name, "_release"}, key_release, exp_r);
      tick();
      chk({name, "_press_fall"}, key_press, 4'h0);
      chk({name, "_release_fall"}, key_release, 4'h0);
   endtask

   task automatic hold(input logic [3:0] v, input int cycles);
      key_in = v;
      repeat (cycles) tick();
   endtask

   typedef struct {
      logic [3:0] kin;
      int         cycles;
      logic [3:0] exp_out;
      logic [3:0] exp_press_any;
      logic [3:0] exp_rel_any;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [3:0] acc_p, acc_r;

      vecs[0] = '{4'hF, 12, 4'hF, 4'h0, 4'h0};
      vecs[1] = '{4'hE, 12, 4'hE, 4'h1, 4'h0};
      vecs[2] = '{4'hF, 12, 4'hF, 4'h0, 4'h1};
      vecs[3] = '{4'h0, 12, 4'h0, 4'hF, 4'h0};
      vecs[4] = '{4'hF,  5, 4'h0, 4'h0, 4'h0};
      vecs[5] = '{4'h0, 12, 4'h0, 4'h0, 4'h0};
      vecs[6] = '{4'hF, 12, 4'hF, 4'h0, 4'hF};
      vecs[7] = '{4'hA, 12, 4'hA, 4'h5, 4'h0};
      vecs[8] = '{4'h5, 12, 4'h5, 4'hA, 4'h5};
      vecs[9] = '{4'hF, 12, 4'hF, 4'h0, 4'hA};

      // 1. Reset behaviour and idle quiet period.
      reset  = 1'b1;
      key_in = 4'hF;
      model_reset();
      #1;
      chk("reset_key_out", key_out, 4'hF);
      chk("reset_press", key_press, 4'h0);
      chk("reset_release", key_release, 4'h0);
      repeat (3) tick();
      chk("in_reset_key_out", key_out, 4'hF);
      reset = 1'b0;
      acc_p = 4'h0;
      acc_r = 4'h0;
      repeat (20) begin
         tick();
         acc_p |= key_press;
         acc_r |= key_release;
      end
      chk("idle_key_out", key_out, 4'hF);
      chk("idle_no_press", acc_p, 4'h0);
      chk("idle_no_release", acc_r, 4'h0);

      // 2. Single press: 10 edges from first sampling edge.
      key_in = 4'hE;
      wait_change("press", 10, 4'hE, 4'h1, 4'h0);
      hold(4'hF, 12);

      // 3. Bounce shorter than the debounce window never changes the output.
      acc_p = 4'h0;
      acc_r = 4'h0;
      for (int r = 0; r < 5; r++) begin
         key_in = 4'hD;
         repeat (7) begin tick(); acc_p |= key_press; acc_r |= key_release; end
         key_in = 4'hF;
         repeat (2) begin tick(); acc_p |= key_press; acc_r |= key_release; end
      end
      chk("bounce_key_out", key_out, 4'hF);
      chk("bounce_no_press", acc_p, 4'h0);
      chk("bounce_no_release", acc_r, 4'h0);
      key_in = 4'hD;
      wait_change("bounce_hold", 10, 4'hD, 4'h2, 4'h0);

      // 4. Release from key_out = E.
      hold(4'hF, 12);
      hold(4'hE, 12);
      chk("pre_release_key_out", key_out, 4'hE);
      key_in = 4'hF;
      wait_change("release", 10, 4'hF, 4'h0, 4'h1);

      // 5. All keys at once.
      hold(4'hF, 4);
      key_in = 4'h0;
      wait_change("all_press", 10, 4'h0, 4'hF, 4'h0);
      hold(4'h0, 4);
      key_in = 4'hF;
      wait_change("all_release", 10, 4'hF, 4'h0, 4'hF);
      hold(4'hF, 4);

      // 6. Asynchronous reset in the middle of a count.
      key_in = 4'hB;
      repeat (5) tick();
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      chk("midreset_key_out", key_out, 4'hF);
      chk("midreset_press", key_press, 4'h0);
      chk("midreset_release", key_release, 4'h0);
      repeat (2) tick();
      #3;
      reset = 1'b0;
      wait_change("post_reset_press", 10, 4'hB, 4'h4, 4'h0);
      hold(4'hF, 12);

      // Table-driven vectors.
      foreach (vecs[v]) begin
         key_in = vecs[v].kin;
         acc_p  = 4'h0;
         acc_r  = 4'h0;
         repeat (vecs[v].cycles) begin
            tick();
            acc_p |= key_press;
            acc_r |= key_release;
         end
         chk($sformatf("vec%0d_key_out", v), key_out, vecs[v].exp_out);
         chk($sformatf("vec%0d_press", v), acc_p, vecs[v].exp_press_any);
         chk($sformatf("vec%0d_release", v), acc_r, vecs[v].exp_rel_any);
      end

      // Randomised activity against the model, with one mid-run reset.
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < NK; b++) begin
            if ($urandom_range(0, 7) == 0) key_in[b] = ~key_in[b];
         end
         if (c == 400) begin
            #3;
            reset = 1'b1;
            model_reset();
            #1;
            chk("rand_reset_key_out", key_out, 4'hF);
         end
         if (c == 402) begin
            #3;
            reset = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
